// File: rtl/vga_timing_generator.sv
// 640x480@60 Hz scan timing. A clock divider produces a pixel tick. On each
// tick the horizontal and vertical scan counters advance. Sync, bright and
// frameStart are taken from the next counter values and registered on the
// same edge, so they always line up with the hCount/vCount presented.
module vga_timing_generator #(
    parameter int CLK_DIV     = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 515
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pixTick,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       frameStart,
    output logic [7:0] frameCount
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
    localparam logic [9:0] H_VS_C  = 10'(H_VIS_START);
    localparam logic [9:0] H_VE_C  = 10'(H_VIS_END);
    localparam logic [9:0] V_VS_C  = 10'(V_VIS_START);
    localparam logic [9:0] V_VE_C  = 10'(V_VIS_END);

    logic [DIV_W-1:0] divCnt;
    logic [DIV_W-1:0] divNext;
    logic [9:0]       hNext;
    logic [9:0]       vNext;
    logic             frameWrap;

    // Next divider value and next scan position assuming a tick happens now.
    always_comb begin
        divNext   = (divCnt == DIV_LAST) ? '0 : divCnt + 1'b1;
        hNext     = hCount;
        vNext     = vCount;
        frameWrap = 1'b0;
        if (hCount == H_LAST) begin
            hNext = '0;
            if (vCount == V_LAST) begin
                vNext     = '0;
                frameWrap = 1'b1;
            end else begin
                vNext = vCount + 10'd1;
            end
        end else begin
            hNext = hCount + 10'd1;
        end
    end

    // Clock divider. pixTick is high during the cycle in which the divider
    // sits at its terminal value, so it is registered from divNext.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt  <= '0;
            pixTick <= 1'b0;
        end else begin
            divCnt  <= divNext;
            pixTick <= (divNext == DIV_LAST);
        end
    end

    // Scan counters and derived outputs. These advance on the edge that
    // closes a pixTick cycle and hold between ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hCount     <= '0;
            vCount     <= '0;
            hSync      <= 1'b0;
            vSync      <= 1'b0;
            bright     <= 1'b0;
            frameStart <= 1'b0;
            frameCount <= '0;
        end else begin
            frameStart <= pixTick && frameWrap;
            if (pixTick) begin
                hCount <= hNext;
                vCount <= vNext;
                hSync  <= (hNext >= H_SYNC_C);
                vSync  <= (vNext >= V_SYNC_C);
                bright <= (hNext >= H_VS_C) && (hNext < H_VE_C) &&
                          (vNext >= V_VS_C) && (vNext < V_VE_C);
                if (frameWrap) begin
                    frameCount <= frameCount + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator using a reduced raster so that several
// hundred frames fit in a short run. Expected scan states are queued when a
// reset episode starts, and a monitor pops one for each pixel advance.
module tb_vga_timing_generator;

    localparam int CD  = 3;
    localparam int HT  = 10;
    localparam int HS  = 2;
    localparam int HVS = 3;
    localparam int HVE = 9;
    localparam int VT  = 8;
    localparam int VS  = 1;
    localparam int VVS = 2;
    localparam int VVE = 7;
    localparam int FRAME   = HT * VT;
    localparam int VISIBLE = (HVE - HVS) * (VVE - VVS);

    logic       clk;
    logic       rst_n;
    logic       pixTick;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       frameStart;
    logic [7:0] frameCount;

    vga_timing_generator #(
        .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_VIS_START(HVS), .H_VIS_END(HVE),
        .V_TOTAL(VT), .V_SYNC(VS), .V_VIS_START(VVS), .V_VIS_END(VVE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixTick(pixTick), .hCount(hCount), .vCount(vCount),
        .hSync(hSync), .vSync(vSync), .bright(bright), .frameStart(frameStart),
        .frameCount(frameCount)
    );

    typedef struct {
        int h;
        int v;
        int hs;
        int vs;
        int br;
        int fs;
        int fc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Scan state after p pixel ticks since reset, straight from the raster rules.
    function automatic exp_t model(input int p);
        exp_t e;
        int pos;
        pos  = p % FRAME;
        e.h  = pos % HT;
        e.v  = pos / HT;
        e.hs = (e.h >= HS) ? 1 : 0;
        e.vs = (e.v >= VS) ? 1 : 0;
        e.br = (e.h >= HVS && e.h < HVE && e.v >= VVS && e.v < VVE) ? 1 : 0;
        e.fs = (pos == 0) ? 1 : 0;
        e.fc = (p / FRAME) % 256;
        return e;
    endfunction

    task automatic checkZero(input string tag);
        check({tag, ".pixTick"}, int'(pixTick), 0);
        check({tag, ".hCount"}, int'(hCount), 0);
        check({tag, ".vCount"}, int'(vCount), 0);
        check({tag, ".hSync"}, int'(hSync), 0);
        check({tag, ".vSync"}, int'(vSync), 0);
        check({tag, ".bright"}, int'(bright), 0);
        check({tag, ".frameStart"}, int'(frameStart), 0);
        check({tag, ".frameCount"}, int'(frameCount), 0);
    endtask

    int edgeCnt = 0;
    int tickSeen = 0;
    int lastH = 0;
    int lastV = 0;
    int lastFc = 0;
    int brightAcc = 0;

    // Rising edges since reset release; the divider phase follows from this.
    always @(posedge clk) begin
        if (!rst_n) edgeCnt = 0;
        else edgeCnt++;
    end

    // Monitor: after each expected tick, compare against the queued state;
    // otherwise confirm that everything holds and frameStart stays low.
    always @(negedge clk) begin
        exp_t e;
        int expPix;
        if (!rst_n) begin
            tickSeen  = 0;
            lastH     = 0;
            lastV     = 0;
            lastFc    = 0;
            brightAcc = 0;
        end else begin
            if (tickSeen != 0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL queueUnderflow actual=extra_tick required=no_tick at %0t", $time);
                end else begin
                    e = q.pop_front();
                    check("hCount", int'(hCount), e.h);
                    check("vCount", int'(vCount), e.v);
                    check("hSync", int'(hSync), e.hs);
                    check("vSync", int'(vSync), e.vs);
                    check("bright", int'(bright), e.br);
                    check("frameStart", int'(frameStart), e.fs);
                    check("frameCount", int'(frameCount), e.fc);
                    if (e.fs != 0) begin
                        check("brightPerFrame", brightAcc, VISIBLE);
                        brightAcc = 0;
                    end
                    brightAcc += int'(bright);
                    lastH  = e.h;
                    lastV  = e.v;
                    lastFc = e.fc;
                end
            end else begin
                check("frameStartIdle", int'(frameStart), 0);
                check("hHold", int'(hCount), lastH);
                check("vHold", int'(vCount), lastV);
                check("frameCountHold", int'(frameCount), lastFc);
            end
            expPix = ((edgeCnt % CD) == (CD - 1)) ? 1 : 0;
            check("pixTick", int'(pixTick), expPix);
            tickSeen = expPix;
        end
    end

    // Stimulus: reset episodes of random length, each ended by an
    // asynchronous reset asserted mid-cycle at an arbitrary scan position.
    // One episode runs past 256 frames to cover the frameCount wrap.
    initial begin
        int n;
        int budget;
        int waited;
        clk   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkZero("initReset");
        for (int ep = 0; ep < 5; ep++) begin
            if (ep == 2) n = 256 * FRAME + int'($urandom_range(1, FRAME - 1));
            else n = int'($urandom_range(1, 3 * FRAME));
            @(negedge clk);
            #1 rst_n = 1'b1;
            for (int p = 1; p <= n; p++) q.push_back(model(p));
            budget = n * CD * 2 + 50;
            waited = 0;
            while (q.size() > 0 && waited < budget) begin
                @(posedge clk);
                waited++;
            end
            if (q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drainTimeout actual=%0d_left required=0_left", q.size());
                q.delete();
            end
            #($urandom_range(1, 4));
            rst_n = 1'b0;
            #1;
            checkZero("asyncReset");
            repeat (3) @(posedge clk);
            #1;
            checkZero("heldReset");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
